// File: rtl/rr_mux_nto1_if.sv
// rr_mux_nto1_if
//   Bundles the per-channel producer handshakes and the single consumer
//   handshake of the round-robin N-to-1 mux.
//
//   Parameters: N (channels), WIDTH (data bits per channel).
//   Signals:
//     in_valid  [N]        producer requests, bit i = channel i
//     in_data   [N*WIDTH]  flattened producer data, channel i at [i*WIDTH +: WIDTH]
//     in_ready  [N]        per-channel accept, one-hot or zero
//     out_valid            output register holds a word
//     out_data  [WIDTH]    registered selected word
//     out_sel   [SELW]     channel index that supplied out_data
//     out_ready            consumer takes out_data this cycle
//   Modports: master = producers/consumer side, slave = mux side.
interface rr_mux_nto1_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  localparam int SELW = $clog2(N);

  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_mux_nto1.sv
// rr_mux_nto1
//   N-to-1 data multiplexer with an internal round-robin arbiter and a
//   one-entry registered output buffer (one cycle latency, full throughput).
//
//   Parameters: N (2..16 channels), WIDTH (data bits per channel).
//   Ports:
//     clk       rising-edge clock
//     rst_n     asynchronous active-low reset
//     pri_mode  (only with RR_MUX_FIXED_PRI_EN) 1 = lowest-index channel wins
//     bus       rr_mux_nto1_if.slave: per-channel valid/ready/data in,
//               registered valid/data/sel out with out_ready backpressure
//
//   Optional feature macro: RR_MUX_FIXED_PRI_EN adds the pri_mode input.
//   Without it the arbiter is pure round-robin.
module rr_mux_nto1 #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef RR_MUX_FIXED_PRI_EN
  input  logic         pri_mode,
`endif
  rr_mux_nto1_if.slave bus
);
  localparam int SELW = $clog2(N);

  // Last-grant pointer and output buffer
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;

  logic             load_s;
  logic             pri_s;
  logic             grant_vld_s;
  logic [SELW-1:0]  grant_s;
  logic [N-1:0]     ready_s;
  logic [WIDTH-1:0] ch_data_s [N];

`ifdef RR_MUX_FIXED_PRI_EN
  assign pri_s = pri_mode;
`else
  assign pri_s = 1'b0;
`endif

  // Buffer can accept a new word when empty or when being drained this cycle
  assign load_s = !out_valid_q | bus.out_ready;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign ch_data_s[g] = bus.in_data[g*WIDTH +: WIDTH];
  end

  // Arbiter: first requesting channel found scanning from base, modulo N.
  // Round-robin starts just after the last grant; fixed priority starts at 0.
  always_comb begin
    int base;
    int idx;
    grant_vld_s = 1'b0;
    grant_s     = '0;
    idx         = 0;
    if (pri_s) begin
      base = 0;
    end else begin
      base = int'(ptr_q) + 1;
    end
    for (int k = 0; k < N; k++) begin
      idx = (base + k) % N;
      if (!grant_vld_s && bus.in_valid[idx[SELW-1:0]]) begin
        grant_vld_s = 1'b1;
        grant_s     = idx[SELW-1:0];
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Per-channel ready: only the granted channel, and only when the buffer can load
  always_comb begin
    ready_s = '0;
    if (load_s && grant_vld_s) begin
      ready_s[grant_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  // Next state of the output buffer and pointer; everything holds on stall
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (load_s) begin
      if (grant_vld_s) begin
        out_valid_d = 1'b1;
        out_data_d  = ch_data_s[grant_s];
        out_sel_d   = grant_s;
        ptr_d       = grant_s;
      end else begin
        // Drained with nothing to replace it: data/sel keep their last values
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; reset pointer to N-1 so channel 0 has first priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= SELW'(N - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.in_ready  = ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_rr_mux_nto1.sv
// Self-checking bench for rr_mux_nto1: a 4-channel and a 3-channel instance
// run side by side against a behavioural model (distance-from-last-grant
// selection over a list of requesters), with directed steps and random traffic.
module tb_rr_mux_nto1;
  logic clk = 1'b0;
  logic rst_n;
  logic pri4 = 1'b0;
  logic pri3 = 1'b0;

  int errors = 0;
  int checks = 0;

  // Model state, index 0 = 4-channel instance, 1 = 3-channel instance
  int m_ptr [2];
  bit m_vld [2];
  int m_dat [2];
  int m_sel [2];
  int nch   [2];

  rr_mux_nto1_if #(.N(4), .WIDTH(8)) if4 ();
  rr_mux_nto1_if #(.N(3), .WIDTH(8)) if3 ();

  rr_mux_nto1 #(.N(4), .WIDTH(8)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef RR_MUX_FIXED_PRI_EN
    .pri_mode (pri4),
`endif
    .bus      (if4)
  );

  rr_mux_nto1 #(.N(3), .WIDTH(8)) dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef RR_MUX_FIXED_PRI_EN
    .pri_mode (pri3),
`endif
    .bus      (if3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner = requester closest after the last grant (or lowest index in fixed mode)
  function automatic int ref_grant(input logic [15:0] vld, input int ptr, input int n, input bit pri);
    int best  = -1;
    int bestd = n;
    for (int c = 0; c < n; c++) begin
      if (vld[c]) begin
        int d;
        d = pri ? c : (c - ptr - 1 + 2 * n) % n;
        if (d < bestd) begin
          bestd = d;
          best  = c;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [15:0] exp_ready(input int d, input logic [15:0] vld, input bit ordy, input bit pri);
    int g;
    g = ref_grant(vld, m_ptr[d], nch[d], pri);
    if ((!m_vld[d] || ordy) && g >= 0) return 16'h1 << g;
    return 16'h0;
  endfunction

  task automatic model_reset();
    nch[0] = 4; nch[1] = 3;
    m_ptr[0] = 3; m_ptr[1] = 2;
    for (int d = 0; d < 2; d++) begin
      m_vld[d] = 1'b0; m_dat[d] = 0; m_sel[d] = 0;
    end
  endtask

  task automatic model_edge(input int d, input logic [15:0] vld, input logic [127:0] dat,
                            input bit ordy, input bit pri);
    int g;
    g = ref_grant(vld, m_ptr[d], nch[d], pri);
    if (!m_vld[d] || ordy) begin
      if (g >= 0) begin
        m_vld[d] = 1'b1;
        m_dat[d] = int'(dat[g*8 +: 8]);
        m_sel[d] = g;
        m_ptr[d] = g;
      end else begin
        m_vld[d] = 1'b0;
      end
    end
  endtask

  // One clock: check ready mid-cycle, advance model at the edge, check outputs after it
  task automatic step();
    @(negedge clk);
    check("in_ready4", 32'(if4.in_ready), 32'(exp_ready(0, 16'(if4.in_valid), if4.out_ready, pri4)));
    check("in_ready3", 32'(if3.in_ready), 32'(exp_ready(1, 16'(if3.in_valid), if3.out_ready, pri3)));
    @(posedge clk);
    model_edge(0, 16'(if4.in_valid), 128'(if4.in_data), if4.out_ready, pri4);
    model_edge(1, 16'(if3.in_valid), 128'(if3.in_data), if3.out_ready, pri3);
    #1;
    check("out_valid4", 32'(if4.out_valid), 32'(m_vld[0]));
    check("out_data4",  32'(if4.out_data),  32'(m_dat[0]));
    check("out_sel4",   32'(if4.out_sel),   32'(m_sel[0]));
    check("out_valid3", 32'(if3.out_valid), 32'(m_vld[1]));
    check("out_data3",  32'(if3.out_data),  32'(m_dat[1]));
    check("out_sel3",   32'(if3.out_sel),   32'(m_sel[1]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    if4.in_valid = 4'h0; if4.in_data = 32'h0; if4.out_ready = 1'b1;
    if3.in_valid = 3'h0; if3.in_data = 24'h0; if3.out_ready = 1'b1;
    model_reset();

    // Power-on reset values
    #2 rst_n = 1'b0;
    #2;
    check("rst_valid4", 32'(if4.out_valid), 32'd0);
    check("rst_data4",  32'(if4.out_data),  32'd0);
    check("rst_sel4",   32'(if4.out_sel),   32'd0);
    check("rst_valid3", 32'(if3.out_valid), 32'd0);
    check("rst_sel3",   32'(if3.out_sel),   32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full contention on 4 channels; ch0/ch2 alternating on the 3-channel part
    if4.in_valid = 4'hF; if4.in_data = 32'h13121110;
    if3.in_valid = 3'b101; if3.in_data = 24'h323130;
    for (int i = 0; i < 8; i++) begin
      step();
      check("t3_sel",   32'(if4.out_sel),   32'(i % 4));
      check("t3_data",  32'(if4.out_data),  32'(32'h10 + i % 4));
      check("t3_valid", 32'(if4.out_valid), 32'd1);
      check("t5_sel",   32'(if3.out_sel),   32'((i % 2) * 2));
    end

    // Asynchronous reset mid-cycle while holding a word
    #2 rst_n = 1'b0;
    #1;
    check("t1_valid", 32'(if4.out_valid), 32'd0);
    check("t1_data",  32'(if4.out_data),  32'd0);
    check("t1_sel",   32'(if4.out_sel),   32'd0);
    model_reset();
    rst_n = 1'b1;
    step();
    check("t1_first", 32'(if4.out_sel), 32'd0);

    // Backpressure: hold 0x11 for three cycles, then resume at ptr+1
    step();
    check("t4_load", 32'(if4.out_data), 32'h11);
    if4.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_rdy",  32'(if4.in_ready), 32'd0);
      check("t4_hold", 32'(if4.out_data), 32'h11);
    end
    if4.out_ready = 1'b1;
    step();
    check("t4_next", 32'(if4.out_sel), 32'd2);

    // Single channel ch2
    if4.in_valid = 4'b0100; if4.in_data = 32'h00A50000;
    #1;
    check("t2_rdy", 32'(if4.in_ready), 32'h4);
    step();
    check("t2_valid", 32'(if4.out_valid), 32'd1);
    check("t2_data",  32'(if4.out_data),  32'hA5);
    check("t2_sel",   32'(if4.out_sel),   32'd2);

    // Random traffic and backpressure on both instances
    for (int i = 0; i < 300; i++) begin
      if4.in_valid  = 4'($urandom_range(0, 15));
      if4.in_data   = $urandom;
      if4.out_ready = ($urandom_range(0, 3) != 0);
      if3.in_valid  = 3'($urandom_range(0, 7));
      if3.in_data   = 24'($urandom);
      if3.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

`ifdef RR_MUX_FIXED_PRI_EN
    // Fixed priority favours ch1; round-robin then resumes after it
    if4.in_valid = 4'b1010; if4.in_data = 32'hD3C2B1A0; if4.out_ready = 1'b1;
    pri4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_pri", 32'(if4.out_sel), 32'd1);
    end
    pri4 = 1'b0;
    step();
    check("t6_rr", 32'(if4.out_sel), 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
